instr_pipe_regs: RTL and testbench
==================================

# instr_pipe_regs

Instruction-word pipeline register chain for the 5-stage MIPS core. It is the writer side of the control unit's instruction inputs. Each cycle it captures the fetched word and advances it through the IF/ID, ID/EX, EX/MEM and MEM/WB instruction latches, which drive the control unit's `iiO`, `ieO`, `emO` and `mwO` inputs. It also detects load-use hazards, inserts bubbles, flushes on taken branches, and freezes on external stall.

## Interface
- `LOAD_OP`, default 6'h23: opcode (bits [31:26]) that identifies a load.
- `NOP_WORD`, default 32'h00000000: word used for bubbles and reset.
- `CNT_W`, default 16: width of the hazard statistics counters.
- `clk` in 1: single core clock; all registers update on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_data` in 32: fetched instruction word.
- `imem_valid` in 1: `imem_data` is valid this cycle.
- `branch_taken` in 1: branch/jump resolved taken in EX (decision from the control unit / `zero`).
- `ext_stall` in 1: memory wait; freezes the whole pipeline.
- `iiO` out 32: IF/ID instruction register.
- `ieO` out 32: ID/EX instruction register.
- `emO` out 32: EX/MEM instruction register.
- `mwO` out 32: MEM/WB instruction register.
- `pc_we` out 1: PC write enable (combinational).
- `load_use_stall` out 1: load-use bubble is being inserted this cycle (combinational).
- `stall_cnt` out CNT_W: count of load-use bubbles inserted.
- `flush_cnt` out CNT_W: count of branch flushes.

## Operation
- Fields: opcode [31:26], rs [25:21], rt [20:16].
- Hazard term `hz`: `ieO`.opcode == LOAD_OP, `ieO`.rt != 0, and `ieO`.rt equals `iiO`.rs or `iiO`.rt.
- Priority per cycle, highest first:
  - **FREEZE** (`ext_stall`=1): all four registers hold; counters hold; `pc_we`=0; `load_use_stall`=0.
  - **FLUSH** (`branch_taken`=1): `iiO`<=NOP_WORD, `ieO`<=NOP_WORD, `emO`<=`ieO`, `mwO`<=`emO`; `pc_we`=1 so the PC loads the target; `flush_cnt`++. `hz` is ignored.
  - **BUBBLE** (`hz`=1): `iiO` holds, `ieO`<=NOP_WORD, `emO`<=`ieO`, `mwO`<=`emO`; `pc_we`=0; `load_use_stall`=1; `stall_cnt`++.
  - **ADVANCE** (otherwise): `mwO`<=`emO`, `emO`<=`ieO`, `ieO`<=`iiO`, `iiO`<=(`imem_valid` ? `imem_data` : NOP_WORD); `pc_we`=`imem_valid`.
- Counters saturate at all-ones and never wrap.
- A NOP_WORD in `ieO` never produces `hz`, because its opcode differs from LOAD_OP or its rt is 0.

## Timing
- Reset (async assert, sync release): `iiO`/`ieO`/`emO`/`mwO` = NOP_WORD; `stall_cnt`=`flush_cnt`=0. Combinational outputs then follow: `pc_we`=`imem_valid`, `load_use_stall`=0.
- Latency: fetched word appears on `iiO` one edge after capture, then `ieO`/`emO`/`mwO` one edge apart each. Minimum 4 edges from fetch to `mwO`.
- A load-use pair costs exactly one bubble. The next cycle `hz`=0, because the load has moved to `emO`.
- `branch_taken` is sampled only on the edge where it is high. Back-to-back assertions flush on every such edge.
- `branch_taken` and `ext_stall` high together: freeze wins. The branch must be held by its source until the freeze ends.
- Reset asserted mid-stall or mid-flush: registers clear immediately; no partial state survives.

## Structure
- Shared package `cpu_pkg`: opcode/field slice constants, LOAD_OP, NOP_WORD, and the stage enum {FREEZE, FLUSH, BUBBLE, ADVANCE}.
- One natural sub-module, `hazard_detect`: combinational `hz` from `iiO`/`ieO`.
- The stage-action decode and the four registers stay in the top.

## Test plan
- **Reset / advance:** reset, then feed 32'h04100000, 32'h08200000, 32'h14000000, 32'h24000000 with `imem_valid`=1. After 4 edges `mwO`=32'h04100000 and `iiO`=32'h24000000; `pc_we`=1 throughout.
- **Load-use:** `ieO`=load with rt=5 (LOAD_OP<<26 | 5<<16), `iiO` with rs=5. One edge: `ieO`=NOP_WORD, `iiO` unchanged, `pc_we`=0, `stall_cnt`=1. Next edge: normal advance.
- **Load with rt=0 or no match:** no bubble; `stall_cnt` stays 0.
- **Branch flush with hazard present:** `branch_taken`=1 with `hz`=1. Result: `iiO`=`ieO`=NOP_WORD, `emO`=previous `ieO`, `flush_cnt`=1, `stall_cnt`=0.
- **Freeze:** `ext_stall`=1 for 3 cycles with `branch_taken`=1. All registers and counters are unchanged and `pc_we`=0. After release the flush occurs on the next edge.
- **Edge cases:** `imem_valid`=0 → `iiO` loads NOP_WORD. Preload `stall_cnt` near max and drive repeated hazards → the counter saturates at 16'hFFFF. `rst_n` pulsed mid-bubble → all outputs return to NOP_WORD asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and the stage-action type for the MIPS core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;

    localparam logic [5:0]  LOAD_OP  = 6'h23;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FREEZE  = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_BUBBLE  = 2'd2,
        ST_ADVANCE = 2'd3
    } stage_e;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Load-use hazard between the ID/EX load and the IF/ID consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect #(
    parameter logic [5:0] LOAD_OP = 6'h23
) (
    input  logic [5:0] ie_opcode,
    input  logic [4:0] ie_rt,
    input  logic [4:0] ii_rs,
    input  logic [4:0] ii_rt,
    output logic       hz
);

    // rt == 0 writes $zero, so a load targeting it can never feed a consumer
    assign hz = (ie_opcode == LOAD_OP) && (ie_rt != 5'd0) &&
                ((ie_rt == ii_rs) || (ie_rt == ii_rt));

endmodule

`default_nettype wire

// File: rtl/instr_pipe_regs.sv
// ============================================================================
// Module      : instr_pipe_regs
// Description : IF/ID, ID/EX, EX/MEM, MEM/WB instruction latches with
//               freeze / flush / load-use bubble control and hazard counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_pipe_regs #(
    parameter logic [5:0]  LOAD_OP  = cpu_pkg::LOAD_OP,
    parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      imem_data,
    input  logic             imem_valid,
    input  logic             branch_taken,
    input  logic             ext_stall,
    output logic [31:0]      iiO,
    output logic [31:0]      ieO,
    output logic [31:0]      emO,
    output logic [31:0]      mwO,
    output logic             pc_we,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import cpu_pkg::*;

    logic [31:0]      r_ii_q, r_ie_q, r_em_q, r_mw_q;
    logic [31:0]      w_ii_d, w_ie_d, w_em_d, w_mw_d;
    logic [CNT_W-1:0] r_stall_cnt_q, r_flush_cnt_q;
    logic [CNT_W-1:0] w_stall_cnt_d, w_flush_cnt_d;
    logic             w_hz;
    stage_e           w_stage;

    hazard_detect #(
        .LOAD_OP (LOAD_OP)
    ) u_hazard_detect (
        .ie_opcode (r_ie_q[OPC_MSB:OPC_LSB]),
        .ie_rt     (r_ie_q[RT_MSB:RT_LSB]),
        .ii_rs     (r_ii_q[RS_MSB:RS_LSB]),
        .ii_rt     (r_ii_q[RT_MSB:RT_LSB]),
        .hz        (w_hz)
    );

    always_comb begin
        w_stage = ST_ADVANCE;
        if (ext_stall) begin
            w_stage = ST_FREEZE;
        end else if (branch_taken) begin
            w_stage = ST_FLUSH;
        end else if (w_hz) begin
            w_stage = ST_BUBBLE;
        end
    end

    always_comb begin
        w_ii_d         = r_ii_q;
        w_ie_d         = r_ie_q;
        w_em_d         = r_em_q;
        w_mw_d         = r_mw_q;
        w_stall_cnt_d  = r_stall_cnt_q;
        w_flush_cnt_d  = r_flush_cnt_q;
        pc_we          = 1'b0;
        load_use_stall = 1'b0;
        unique case (w_stage)
            ST_FREEZE: begin
            end
            ST_FLUSH: begin
                w_ii_d        = NOP_WORD;
                w_ie_d        = NOP_WORD;
                w_em_d        = r_ie_q;
                w_mw_d        = r_em_q;
                pc_we         = 1'b1;
                w_flush_cnt_d = (&r_flush_cnt_q) ? r_flush_cnt_q
                                                 : r_flush_cnt_q + CNT_W'(1);
            end
            ST_BUBBLE: begin
                w_ie_d         = NOP_WORD;
                w_em_d         = r_ie_q;
                w_mw_d         = r_em_q;
                load_use_stall = 1'b1;
                w_stall_cnt_d  = (&r_stall_cnt_q) ? r_stall_cnt_q
                                                  : r_stall_cnt_q + CNT_W'(1);
            end
            ST_ADVANCE: begin
                w_ii_d = imem_valid ? imem_data : NOP_WORD;
                w_ie_d = r_ii_q;
                w_em_d = r_ie_q;
                w_mw_d = r_em_q;
                pc_we  = imem_valid;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ii_q        <= NOP_WORD;
            r_ie_q        <= NOP_WORD;
            r_em_q        <= NOP_WORD;
            r_mw_q        <= NOP_WORD;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_ii_q        <= w_ii_d;
            r_ie_q        <= w_ie_d;
            r_em_q        <= w_em_d;
            r_mw_q        <= w_mw_d;
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign iiO       = r_ii_q;
    assign ieO       = r_ie_q;
    assign emO       = r_em_q;
    assign mwO       = r_mw_q;
    assign stall_cnt = r_stall_cnt_q;
    assign flush_cnt = r_flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_pipe_regs.sv
// ============================================================================
// Module      : tb_instr_pipe_regs
// Description : Randomized and directed checks of instr_pipe_regs against a
//               behavioural pipeline model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_pipe_regs;

    localparam logic [5:0]  C_LOAD = 6'h23;
    localparam logic [31:0] C_NOP  = 32'h0000_0000;
    localparam int          C_SMAX = 15;
    localparam int          C_FMAX = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_data = '0;
    logic        imem_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic        ext_stall = 1'b0;

    logic [31:0] iiO, ieO, emO, mwO;
    logic        pc_we, load_use_stall;
    logic [15:0] stall_cnt, flush_cnt;
    logic [31:0] s_iiO, s_ieO, s_emO, s_mwO;
    logic        s_pc_we, s_load_use_stall;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    instr_pipe_regs dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_data      (imem_data),
        .imem_valid     (imem_valid),
        .branch_taken   (branch_taken),
        .ext_stall      (ext_stall),
        .iiO            (iiO),
        .ieO            (ieO),
        .emO            (emO),
        .mwO            (mwO),
        .pc_we          (pc_we),
        .load_use_stall (load_use_stall),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run
    instr_pipe_regs #(.CNT_W(4)) dut_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_data      (imem_data),
        .imem_valid     (imem_valid),
        .branch_taken   (branch_taken),
        .ext_stall      (ext_stall),
        .iiO            (s_iiO),
        .ieO            (s_ieO),
        .emO            (s_emO),
        .mwO            (s_mwO),
        .pc_we          (s_pc_we),
        .load_use_stall (s_load_use_stall),
        .stall_cnt      (s_stall_cnt),
        .flush_cnt      (s_flush_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Model: pipe[0] is the newest latch (IF/ID), pipe[3] the oldest (MEM/WB)
    logic [31:0] m_pipe [4];
    int          m_stall, m_flush, m_sstall, m_sflush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rt,
                                       input logic [15:0] lo);
        return {op, 5'(rs), 5'(rt), lo};
    endfunction

    function automatic bit model_hazard();
        logic [31:0] prod, cons;
        prod = m_pipe[1];
        cons = m_pipe[0];
        if (prod[31:26] != C_LOAD) return 1'b0;
        if (prod[20:16] == 5'd0) return 1'b0;
        return (prod[20:16] == cons[25:21]) || (prod[20:16] == cons[20:16]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pipe[i] = C_NOP;
        m_stall = 0; m_flush = 0; m_sstall = 0; m_sflush = 0;
    endtask

    task automatic check_regs(input string where);
        chk({where, ".iiO"}, iiO, m_pipe[0]);
        chk({where, ".ieO"}, ieO, m_pipe[1]);
        chk({where, ".emO"}, emO, m_pipe[2]);
        chk({where, ".mwO"}, mwO, m_pipe[3]);
        chk({where, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        chk({where, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
        chk({where, ".sat_stall"}, 32'(s_stall_cnt), 32'(m_sstall));
        chk({where, ".sat_flush"}, 32'(s_flush_cnt), 32'(m_sflush));
    endtask

    // Called at a falling edge: drive, check combinational outputs, clock, check registers
    task automatic do_cycle(input logic [31:0] data, input logic valid,
                            input logic br, input logic stl);
        bit          freeze, flush, bubble;
        logic        exp_pc;
        logic [31:0] top;
        imem_data    = data;
        imem_valid   = valid;
        branch_taken = br;
        ext_stall    = stl;
        #1;
        freeze = stl;
        flush  = !stl && br;
        bubble = !stl && !br && model_hazard();
        exp_pc = freeze ? 1'b0 : flush ? 1'b1 : bubble ? 1'b0 : valid;
        chk("pc_we", 32'(pc_we), 32'(exp_pc));
        chk("load_use_stall", 32'(load_use_stall), 32'(bubble));
        @(posedge clk);
        if (!freeze) begin
            top = flush ? C_NOP : bubble ? m_pipe[0] : (valid ? data : C_NOP);
            m_pipe[3] = m_pipe[2];
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = (flush || bubble) ? C_NOP : m_pipe[0];
            m_pipe[0] = top;
            if (flush) begin
                m_flush  = (m_flush  < C_FMAX) ? m_flush  + 1 : m_flush;
                m_sflush = (m_sflush < C_SMAX) ? m_sflush + 1 : m_sflush;
            end
            if (bubble) begin
                m_stall  = (m_stall  < C_FMAX) ? m_stall  + 1 : m_stall;
                m_sstall = (m_sstall < C_SMAX) ? m_sstall + 1 : m_sstall;
            end
        end
        @(negedge clk);
        check_regs("cyc");
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 2))
            0:       op = C_LOAD;
            1:       op = 6'h00;
            default: op = 6'h08;
        endcase
        return mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  16'($urandom));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] lw5, use5, held;
        lw5  = mk(C_LOAD, 0, 5, 16'h0000);
        use5 = mk(6'h00, 5, 0, 16'h0000);

        // Straight advance
        apply_reset();
        do_cycle(32'h0410_0000, 1'b1, 1'b0, 1'b0);
        do_cycle(32'h0820_0000, 1'b1, 1'b0, 1'b0);
        do_cycle(32'h1400_0000, 1'b1, 1'b0, 1'b0);
        do_cycle(32'h2400_0000, 1'b1, 1'b0, 1'b0);
        chk("adv.mwO", mwO, 32'h0410_0000);
        chk("adv.iiO", iiO, 32'h2400_0000);

        // Load-use: exactly one bubble
        apply_reset();
        do_cycle(lw5, 1'b1, 1'b0, 1'b0);
        do_cycle(use5, 1'b1, 1'b0, 1'b0);
        do_cycle(32'h0820_0000, 1'b1, 1'b0, 1'b0);
        chk("lu.ieO", ieO, C_NOP);
        chk("lu.iiO", iiO, use5);
        chk("lu.stall_cnt", 32'(stall_cnt), 32'd1);
        do_cycle(32'h0820_0000, 1'b1, 1'b0, 1'b0);
        chk("lu.next_iiO", iiO, 32'h0820_0000);

        // Load to $zero, then a load with no matching consumer
        apply_reset();
        do_cycle(mk(C_LOAD, 0, 0, 16'h0), 1'b1, 1'b0, 1'b0);
        do_cycle(mk(6'h00, 0, 0, 16'h0), 1'b1, 1'b0, 1'b0);
        do_cycle(lw5, 1'b1, 1'b0, 1'b0);
        do_cycle(mk(6'h00, 6, 7, 16'h0), 1'b1, 1'b0, 1'b0);
        do_cycle(32'h0, 1'b0, 1'b0, 1'b0);
        chk("nohz.stall_cnt", 32'(stall_cnt), 32'd0);
        chk("invalid.iiO", iiO, C_NOP);

        // Flush overrides a pending hazard
        apply_reset();
        do_cycle(lw5, 1'b1, 1'b0, 1'b0);
        do_cycle(use5, 1'b1, 1'b0, 1'b0);
        do_cycle(32'h0820_0000, 1'b1, 1'b1, 1'b0);
        chk("fl.iiO", iiO, C_NOP);
        chk("fl.ieO", ieO, C_NOP);
        chk("fl.emO", emO, lw5);
        chk("fl.flush_cnt", 32'(flush_cnt), 32'd1);
        chk("fl.stall_cnt", 32'(stall_cnt), 32'd0);

        // Freeze beats a held branch, flush lands after release
        apply_reset();
        do_cycle(32'h0410_0000, 1'b1, 1'b0, 1'b0);
        do_cycle(32'h0820_0000, 1'b1, 1'b0, 1'b0);
        held = iiO;
        for (int i = 0; i < 3; i++) do_cycle(32'h1400_0000, 1'b1, 1'b1, 1'b1);
        chk("frz.iiO", iiO, held);
        chk("frz.flush_cnt", 32'(flush_cnt), 32'd0);
        do_cycle(32'h1400_0000, 1'b1, 1'b1, 1'b0);
        chk("frz.rel_emO", emO, 32'h0410_0000);
        chk("frz.rel_flush_cnt", 32'(flush_cnt), 32'd1);

        // Random traffic, dense in load-use pairs
        apply_reset();
        for (int n = 0; n < 2000; n++) begin
            do_cycle(rand_instr(), 1'($urandom_range(0, 9) < 8),
                     1'($urandom_range(0, 99) < 8), 1'($urandom_range(0, 9) == 0));
        end
        chk("sat.stall_full", 32'(s_stall_cnt), 32'd15);

        // Asynchronous reset in the middle of a bubble
        apply_reset();
        do_cycle(lw5, 1'b1, 1'b0, 1'b0);
        do_cycle(use5, 1'b1, 1'b0, 1'b0);
        imem_data = 32'h0820_0000; imem_valid = 1'b1;
        #1;
        chk("rstmid.pre_lus", 32'(load_use_stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("rstmid");
        chk("rstmid.lus", 32'(load_use_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(32'h0410_0000, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
